// File: rtl/multi_cycle_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// multi_cycle_ctrl_pkg
//   Shared constants for the multi-cycle RV32 sequencer:
//     - OPCODE_*   : RV32 major opcodes handled by the sequencer
//     - ALU_OP_*   : ALU operation class presented to the datapath ALU decoder
//     - CTRL_ST_*  : 3-bit sequencer state encodings
//     - CTRL_ERR_* : sticky trap cause codes reported on Err_o
//   is_legal_opcode() tells DECODE whether an opcode belongs to the subset.
// ----------------------------------------------------------------------------
package multi_cycle_ctrl_pkg;

    // RV32 major opcodes
    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;

    // ALU operation class; 2'b00 is what the ALU sees outside EXEC
    localparam logic [1:0] ALU_OP_REG = 2'b10;
    localparam logic [1:0] ALU_OP_IMM = 2'b01;

    // Trap cause codes
    localparam logic [1:0] CTRL_ERR_NONE    = 2'd0;
    localparam logic [1:0] CTRL_ERR_ILLEGAL = 2'd1;
    localparam logic [1:0] CTRL_ERR_IMEM_TO = 2'd2;
    localparam logic [1:0] CTRL_ERR_DMEM_TO = 2'd3;

    // Sequencer states
    typedef enum logic [2:0] {
        CTRL_ST_IDLE   = 3'd0,
        CTRL_ST_FETCH  = 3'd1,
        CTRL_ST_DECODE = 3'd2,
        CTRL_ST_EXEC   = 3'd3,
        CTRL_ST_MEM    = 3'd4,
        CTRL_ST_WB     = 3'd5,
        CTRL_ST_TRAP   = 3'd6
    } ctrl_state_e;

    // True for every opcode the sequencer knows how to step through
    function automatic logic is_legal_opcode(input logic [6:0] op);
        logic legal;
        case (op)
            OPCODE_OP, OPCODE_OP_IMM, OPCODE_LOAD,
            OPCODE_STORE, OPCODE_BRANCH: legal = 1'b1;
            default:                     legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/multi_cycle_ctrl_mem_wait_timer.sv
// ----------------------------------------------------------------------------
// mem_wait_timer
//   Wait-state watchdog shared by the FETCH and MEM phases. Counts cycles in
//   which a memory request is outstanding and not yet acknowledged.
//   Ports:
//     clk     in  clock, rising edge
//     rst_n   in  asynchronous active-low reset
//     clear   in  restart the count at zero (takes priority over enable)
//     enable  in  one more cycle spent waiting
//     expired out count has reached MAX_WAIT
//   The counter saturates at MAX_WAIT so it can never wrap back into a
//   "not expired" value if the owner keeps enable high.
// ----------------------------------------------------------------------------
module mem_wait_timer #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [W-1:0] LIMIT = W'(MAX_WAIT);

    logic [W-1:0] count_r;

    // Wait-cycle counter: clear on phase entry, count while waiting, saturate
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (enable && (count_r != LIMIT)) begin
            count_r <= count_r + W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = (count_r == LIMIT);

endmodule

// File: rtl/multi_cycle_ctrl.sv
// ----------------------------------------------------------------------------
// multi_cycle_ctrl
//   Multi-cycle sequencer for the RV32 subset OP, OP-IMM, LOAD, STORE, BRANCH.
//   Steps a shared datapath through FETCH / DECODE / EXEC / MEM / WB, handshakes
//   with instruction and data memories and traps on illegal opcodes or memory
//   wait timeouts. A trap is left only through reset.
//
//   Optional feature macro: MULTI_CYCLE_CTRL_PERF_CNT_EN
//     When defined, adds CycleCnt_o (cycles with Busy_o=1) and InstRet_o
//     (retired instructions, one per PCWrite_o) of width CNT_WIDTH.
//
//   Ports:
//     clk_i        in   clock, rising edge
//     rst_i        in   asynchronous active-low reset
//     start_i      in   leave IDLE and begin fetching
//     halt_i       in   return to IDLE at the next instruction boundary
//     Opcode_i     in   opcode field of the instruction register
//     Zero_i       in   ALU zero flag (branch taken condition)
//     IMemReady_i  in   instruction memory data valid
//     DMemReady_i  in   data memory access complete
//     IMemReq_o    out  instruction fetch request
//     IRWrite_o    out  load instruction register
//     DMemReq_o    out  data memory request
//     DMemWe_o     out  data memory write (qualifies DMemReq_o)
//     ALUSrc_o     out  1 = immediate operand
//     ALUOp_o      out  ALU operation class (ALU_OP_REG / ALU_OP_IMM)
//     RegWrite_o   out  register-file write strobe
//     MemToReg_o   out  write-back selects memory data
//     PCWrite_o    out  PC update strobe (exactly once per instruction)
//     PCSrc_o      out  0 = PC+4, 1 = branch target
//     Busy_o       out  sequencer is neither IDLE nor TRAP
//     Err_o        out  sticky trap cause
//     CycleCnt_o   out  busy-cycle counter (feature build only)
//     InstRet_o    out  retired-instruction counter (feature build only)
//
//   Outputs are decoded from the registered state and latched opcode. The
//   handshake strobes that must coincide with a ready (IRWrite_o, the STORE
//   PCWrite_o) follow the ready input within the same cycle, and PCSrc_o in a
//   branch EXEC follows Zero_i. Because nothing is decoded from the previous
//   cycle, asserting reset clears every strobe immediately.
// ----------------------------------------------------------------------------
module multi_cycle_ctrl
    import multi_cycle_ctrl_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 15
`ifdef MULTI_CYCLE_CTRL_PERF_CNT_EN
    ,
    parameter int unsigned CNT_WIDTH = 32
`endif
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       halt_i,
    input  logic [6:0] Opcode_i,
    input  logic       Zero_i,
    input  logic       IMemReady_i,
    input  logic       DMemReady_i,
    output logic       IMemReq_o,
    output logic       IRWrite_o,
    output logic       DMemReq_o,
    output logic       DMemWe_o,
    output logic       ALUSrc_o,
    output logic [1:0] ALUOp_o,
    output logic       RegWrite_o,
    output logic       MemToReg_o,
    output logic       PCWrite_o,
    output logic       PCSrc_o,
    output logic       Busy_o,
    output logic [1:0] Err_o
`ifdef MULTI_CYCLE_CTRL_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] CycleCnt_o,
    output logic [CNT_WIDTH-1:0] InstRet_o
`endif
);

    ctrl_state_e state_r;
    ctrl_state_e state_next_s;
    logic [6:0]  opcode_r;
    logic [1:0]  err_r;
    logic [1:0]  err_code_s;
    logic        timer_clear_s;
    logic        timer_enable_s;
    logic        timer_expired_s;

    // ------------------------------------------------------------------
    // Wait-state watchdog. Restarted whenever FETCH or MEM is entered from
    // a different state; a MEM -> FETCH hand-over (STORE retiring) is a
    // fresh entry and therefore also restarts it.
    // ------------------------------------------------------------------
    assign timer_clear_s  = ((state_next_s == CTRL_ST_FETCH) || (state_next_s == CTRL_ST_MEM))
                            && (state_next_s != state_r);
    assign timer_enable_s = ((state_r == CTRL_ST_FETCH) && !IMemReady_i)
                            || ((state_r == CTRL_ST_MEM) && !DMemReady_i);

    mem_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk     (clk_i),
        .rst_n   (rst_i),
        .clear   (timer_clear_s),
        .enable  (timer_enable_s),
        .expired (timer_expired_s)
    );

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r <= CTRL_ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Opcode latch: captured in DECODE, steers EXEC/MEM/WB
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            opcode_r <= 7'd0;
        end else if (state_r == CTRL_ST_DECODE) begin
            opcode_r <= Opcode_i;
        end else begin
            opcode_r <= opcode_r;
        end
    end

    // Sticky error: written only on the transition into TRAP
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            err_r <= CTRL_ERR_NONE;
        end else if ((state_r != CTRL_ST_TRAP) && (state_next_s == CTRL_ST_TRAP)) begin
            err_r <= err_code_s;
        end else begin
            err_r <= err_r;
        end
    end

    assign Err_o = err_r;

    // Next-state and output decode
    always_comb begin
        state_next_s = state_r;
        err_code_s   = CTRL_ERR_NONE;
        IMemReq_o    = 1'b0;
        IRWrite_o    = 1'b0;
        DMemReq_o    = 1'b0;
        DMemWe_o     = 1'b0;
        ALUSrc_o     = 1'b0;
        ALUOp_o      = 2'b00;
        RegWrite_o   = 1'b0;
        MemToReg_o   = 1'b0;
        PCWrite_o    = 1'b0;
        PCSrc_o      = 1'b0;
        Busy_o       = 1'b1;

        case (state_r)
            CTRL_ST_IDLE: begin
                Busy_o = 1'b0;
                if (start_i) begin
                    state_next_s = CTRL_ST_FETCH;
                end else begin
                    state_next_s = CTRL_ST_IDLE;
                end
            end

            CTRL_ST_FETCH: begin
                IMemReq_o = 1'b1;
                // A ready arriving on the expiry cycle still wins
                if (IMemReady_i) begin
                    IRWrite_o    = 1'b1;
                    state_next_s = CTRL_ST_DECODE;
                end else if (timer_expired_s) begin
                    err_code_s   = CTRL_ERR_IMEM_TO;
                    state_next_s = CTRL_ST_TRAP;
                end else begin
                    state_next_s = CTRL_ST_FETCH;
                end
            end

            CTRL_ST_DECODE: begin
                if (is_legal_opcode(Opcode_i)) begin
                    state_next_s = CTRL_ST_EXEC;
                end else begin
                    err_code_s   = CTRL_ERR_ILLEGAL;
                    state_next_s = CTRL_ST_TRAP;
                end
            end

            CTRL_ST_EXEC: begin
                case (opcode_r)
                    OPCODE_OP: begin
                        ALUOp_o      = ALU_OP_REG;
                        state_next_s = CTRL_ST_WB;
                    end
                    OPCODE_OP_IMM: begin
                        ALUSrc_o     = 1'b1;
                        ALUOp_o      = ALU_OP_IMM;
                        state_next_s = CTRL_ST_WB;
                    end
                    OPCODE_LOAD, OPCODE_STORE: begin
                        ALUSrc_o     = 1'b1;
                        ALUOp_o      = ALU_OP_IMM;
                        state_next_s = CTRL_ST_MEM;
                    end
                    OPCODE_BRANCH: begin
                        ALUOp_o      = ALU_OP_REG;
                        PCWrite_o    = 1'b1;
                        PCSrc_o      = Zero_i;
                        state_next_s = halt_i ? CTRL_ST_IDLE : CTRL_ST_FETCH;
                    end
                    default: begin
                        // Latched opcode was screened in DECODE; reaching here means corruption
                        err_code_s   = CTRL_ERR_ILLEGAL;
                        state_next_s = CTRL_ST_TRAP;
                    end
                endcase
            end

            CTRL_ST_MEM: begin
                DMemReq_o = 1'b1;
                DMemWe_o  = (opcode_r == OPCODE_STORE);
                if (DMemReady_i) begin
                    if (opcode_r == OPCODE_STORE) begin
                        // STORE retires here; it has no write-back phase
                        PCWrite_o    = 1'b1;
                        state_next_s = halt_i ? CTRL_ST_IDLE : CTRL_ST_FETCH;
                    end else begin
                        state_next_s = CTRL_ST_WB;
                    end
                end else if (timer_expired_s) begin
                    err_code_s   = CTRL_ERR_DMEM_TO;
                    state_next_s = CTRL_ST_TRAP;
                end else begin
                    state_next_s = CTRL_ST_MEM;
                end
            end

            CTRL_ST_WB: begin
                RegWrite_o   = 1'b1;
                MemToReg_o   = (opcode_r == OPCODE_LOAD);
                PCWrite_o    = 1'b1;
                state_next_s = halt_i ? CTRL_ST_IDLE : CTRL_ST_FETCH;
            end

            CTRL_ST_TRAP: begin
                Busy_o       = 1'b0;
                state_next_s = CTRL_ST_TRAP;
            end

            default: begin
                // Unused encoding: park in the safe state
                Busy_o       = 1'b0;
                err_code_s   = CTRL_ERR_ILLEGAL;
                state_next_s = CTRL_ST_TRAP;
            end
        endcase
    end

`ifdef MULTI_CYCLE_CTRL_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] cycle_cnt_r;
    logic [CNT_WIDTH-1:0] inst_ret_r;

    // Busy-cycle counter, wraps naturally
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cycle_cnt_r <= '0;
        end else if (Busy_o) begin
            cycle_cnt_r <= cycle_cnt_r + CNT_WIDTH'(1);
        end else begin
            cycle_cnt_r <= cycle_cnt_r;
        end
    end

    // Retired-instruction counter: every instruction strobes PCWrite_o once
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            inst_ret_r <= '0;
        end else if (PCWrite_o) begin
            inst_ret_r <= inst_ret_r + CNT_WIDTH'(1);
        end else begin
            inst_ret_r <= inst_ret_r;
        end
    end

    assign CycleCnt_o = cycle_cnt_r;
    assign InstRet_o  = inst_ret_r;
`else
    // Performance counters are not built in this configuration.
`endif

endmodule
